// File: rtl/md5_mem_responder.sv
// md5_mem_responder: word-addressed RAM that acts as the memory slave for the
// md5 core's dual-channel minimal memory interface.
//   clk, reset           : single clock, synchronous active-high reset
//   Mout_*               : two core channels (ch0 low slice, ch1 high slice)
//   M_Rdata_ram          : per-channel read data, held until the next read
//   M_DataRdy            : per-channel one-cycle completion pulse, 1-cycle latency
//   host_we/addr/wdata   : full-word host write (preload)
//   host_rdata           : registered RAM[host_addr], read-before-write
//   err                  : sticky flag for any illegal core access

// Per-channel request decode: address offset, legality, byte enables and
// lane-aligned write data.
module md5_mem_chan_dec #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int          DEPTH     = 64,
  parameter int          AW        = 6
) (
  input  logic          oe,
  input  logic          we,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic [5:0]    size,
  output logic          req,
  output logic          rd,
  output logic          wr,
  output logic          ok,
  output logic [AW-1:0] word,
  output logic [1:0]    lane,
  output logic [3:0]    be,
  output logic [31:0]   wdat_sh,
  output logic [31:0]   mask
);
  logic [31:0] off;
  logic [3:0]  be_n;
  logic        al_ok;
  logic        in_rng;

  always_comb begin
    off   = addr - BASE_ADDR;
    req   = oe | we;
    wr    = we;
    rd    = oe & ~we;   // oe+we together is a write
    word  = off[AW+1:2];
    lane  = off[1:0];
    mask  = 32'h0;
    be_n  = 4'b0000;
    al_ok = 1'b0;
    unique case (size)
      6'd8:  begin mask = 32'h000000ff; be_n = 4'b0001; al_ok = 1'b1;          end
      6'd16: begin mask = 32'h0000ffff; be_n = 4'b0011; al_ok = ~lane[0];      end
      6'd32: begin mask = 32'hffffffff; be_n = 4'b1111; al_ok = (lane == 2'd0); end
      default: ;
    endcase
    in_rng  = off < 32'(4 * DEPTH);
    ok      = in_rng & al_ok;   // al_ok is only set for legal sizes
    be      = ok ? (be_n << lane) : 4'b0000;
    wdat_sh = (wdata & mask) << {lane, 3'b000};
  end
endmodule

module md5_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int          DEPTH     = 64,
  parameter int          AW        = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    Mout_oe_ram,
  input  logic [1:0]    Mout_we_ram,
  input  logic [63:0]   Mout_addr_ram,
  input  logic [63:0]   Mout_Wdata_ram,
  input  logic [11:0]   Mout_data_ram_size,
  output logic [63:0]   M_Rdata_ram,
  output logic [1:0]    M_DataRdy,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  output logic [31:0]   host_rdata,
  output logic          err
);
  localparam int NCH = 2;

  logic [NCH-1:0]           req, rd, wr, ok;
  logic [NCH-1:0][AW-1:0]   word;
  logic [NCH-1:0][1:0]      lane;
  logic [NCH-1:0][3:0]      be;
  logic [NCH-1:0][31:0]     wsh, mask;

  logic [DEPTH-1:0][31:0]   mem_q, mem_d;
  logic [NCH-1:0][31:0]     rdata_q, rdata_d;
  logic [NCH-1:0]           rdy_q, rdy_d;
  logic [31:0]              host_rdata_q, host_rdata_d;
  logic                     err_q, err_d;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    md5_mem_chan_dec #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH), .AW(AW)) u_dec (
      .oe      (Mout_oe_ram[g]),
      .we      (Mout_we_ram[g]),
      .addr    (Mout_addr_ram[32*g +: 32]),
      .wdata   (Mout_Wdata_ram[32*g +: 32]),
      .size    (Mout_data_ram_size[6*g +: 6]),
      .req     (req[g]),
      .rd      (rd[g]),
      .wr      (wr[g]),
      .ok      (ok[g]),
      .word    (word[g]),
      .lane    (lane[g]),
      .be      (be[g]),
      .wdat_sh (wsh[g]),
      .mask    (mask[g])
    );
  end

  always_comb begin
    // Write priority by ordering: host first, then ch0, then ch1 overrides.
    mem_d = mem_q;
    if (host_we) mem_d[host_addr] = host_wdata;
    for (int c = 0; c < NCH; c++) begin
      if (wr[c]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[c][b]) mem_d[word[c]][8*b +: 8] = wsh[c][8*b +: 8];
        end
      end
    end

    // Every request is acked, legal or not, so the core never stalls.
    rdy_d = req;

    err_d = err_q;
    for (int c = 0; c < NCH; c++) begin
      if (req[c] && (!ok[c] || (Mout_oe_ram[c] && Mout_we_ram[c]))) err_d = 1'b1;
    end

    // Reads see mem_q, i.e. the value before this cycle's writes.
    for (int c = 0; c < NCH; c++) begin
      rdata_d[c] = rdata_q[c];
      if (rd[c]) rdata_d[c] = ok[c] ? ((mem_q[word[c]] >> {lane[c], 3'b000}) & mask[c]) : 32'h0;
    end

    host_rdata_d = mem_q[host_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q        <= '0;
      rdata_q      <= '0;
      rdy_q        <= '0;
      host_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rdata_q      <= rdata_d;
      rdy_q        <= rdy_d;
      host_rdata_q <= host_rdata_d;
      err_q        <= err_d;
    end
  end

  assign M_Rdata_ram = rdata_q;
  assign M_DataRdy   = rdy_q;
  assign host_rdata  = host_rdata_q;
  assign err         = err_q;
endmodule

// File: tb/tb_md5_mem_responder.sv
// Scoreboard bench for md5_mem_responder: a byte-array model predicts each
// cycle's outputs at issue time; a negedge monitor pops and compares.
module tb_md5_mem_responder;
  localparam logic [31:0] BASE = 32'h40000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Mout_oe_ram, Mout_we_ram;
  logic [63:0] Mout_addr_ram, Mout_Wdata_ram;
  logic [11:0] Mout_data_ram_size;
  logic [63:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;
  logic        host_we;
  logic [5:0]  host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic        err;

  md5_mem_responder dut (
    .clk(clk), .reset(reset),
    .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram),
    .Mout_addr_ram(Mout_addr_ram), .Mout_Wdata_ram(Mout_Wdata_ram),
    .Mout_data_ram_size(Mout_data_ram_size),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        oe, we;
    logic [31:0] addr, wdata;
    logic [5:0]  size;
  } req_t;

  typedef struct {
    logic [1:0]  rdy;
    logic [63:0] rdata;
    logic [31:0] host;
    logic        err;
  } st_t;

  st_t         stq[$];
  logic [32:0] ackq0[$], ackq1[$];   // {is_read, data}

  logic [7:0]  mem_m [256];
  logic [31:0] rdata_m [2];
  logic        err_m;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic oe, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [5:0] size);
    req_t r;
    r.oe = oe; r.we = we; r.addr = addr; r.wdata = wdata; r.size = size;
    return r;
  endfunction

  // One clock cycle: drive inputs, predict the outputs after the next edge.
  task automatic cyc(input logic rst, input req_t r0, input req_t r1,
                     input logic hwe, input logic [5:0] ha, input logic [31:0] hwd);
    req_t        r[2];
    st_t         s;
    logic [31:0] off;
    logic [31:0] data;
    int          nb, hb;
    bit          legal;
    r[0] = r0; r[1] = r1;
    reset              = rst;
    Mout_oe_ram        = {r1.oe, r0.oe};
    Mout_we_ram        = {r1.we, r0.we};
    Mout_addr_ram      = {r1.addr, r0.addr};
    Mout_Wdata_ram     = {r1.wdata, r0.wdata};
    Mout_data_ram_size = {r1.size, r0.size};
    host_we = hwe; host_addr = ha; host_wdata = hwd;
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_m[i] = 8'h0;
      rdata_m[0] = 0; rdata_m[1] = 0; err_m = 0;
      s.rdy = 0; s.rdata = 0; s.host = 0; s.err = 0;
    end else begin
      hb = 4 * int'(ha);
      s.host = {mem_m[hb+3], mem_m[hb+2], mem_m[hb+1], mem_m[hb]};
      // Reads from the old contents first.
      for (int c = 0; c < 2; c++) begin
        if (r[c].oe || r[c].we) begin
          off   = r[c].addr - BASE;
          nb    = int'(r[c].size) / 8;
          legal = (r[c].size == 8 || r[c].size == 16 || r[c].size == 32) &&
                  off < 256 && (off % nb) == 0;
          if (!legal || (r[c].oe && r[c].we)) err_m = 1'b1;
          if (r[c].oe && !r[c].we) begin
            data = 0;
            if (legal) for (int k = 0; k < nb; k++) data |= 32'(mem_m[off+k]) << (8*k);
            rdata_m[c] = data;
            if (c == 0) ackq0.push_back({1'b1, data}); else ackq1.push_back({1'b1, data});
          end else begin
            if (c == 0) ackq0.push_back(33'h0); else ackq1.push_back(33'h0);
          end
        end
      end
      // Writes: host, then ch0, then ch1 (later one wins on shared bytes).
      if (hwe) for (int k = 0; k < 4; k++) mem_m[hb+k] = hwd[8*k +: 8];
      for (int c = 0; c < 2; c++) begin
        if (r[c].we) begin
          off   = r[c].addr - BASE;
          nb    = int'(r[c].size) / 8;
          legal = (r[c].size == 8 || r[c].size == 16 || r[c].size == 32) &&
                  off < 256 && (off % nb) == 0;
          if (legal) for (int k = 0; k < nb; k++) mem_m[off+k] = r[c].wdata[8*k +: 8];
        end
      end
      s.rdy   = {r1.oe | r1.we, r0.oe | r0.we};
      s.rdata = {rdata_m[1], rdata_m[0]};
      s.err   = err_m;
    end
    stq.push_back(s);
    @(posedge clk); #1;
  endtask

  // Monitor: per-cycle status plus per-channel ack scoreboard.
  always @(negedge clk) begin
    st_t         s;
    logic [32:0] a;
    if (stq.size() > 0) begin
      s = stq.pop_front();
      chk("rdy", 64'(M_DataRdy), 64'(s.rdy));
      chk("rdata_hold", M_Rdata_ram, s.rdata);
      chk("host_rdata", 64'(host_rdata), 64'(s.host));
      chk("err", 64'(err), 64'(s.err));
    end
    if (M_DataRdy[0] === 1'b1) begin
      if (ackq0.size() == 0) chk("ack0_unexpected", 64'd1, 64'd0);
      else begin
        a = ackq0.pop_front();
        if (a[32]) chk("ch0_read", 64'(M_Rdata_ram[31:0]), 64'(a[31:0]));
      end
    end
    if (M_DataRdy[1] === 1'b1) begin
      if (ackq1.size() == 0) chk("ack1_unexpected", 64'd1, 64'd0);
      else begin
        a = ackq1.pop_front();
        if (a[32]) chk("ch1_read", 64'(M_Rdata_ram[63:32]), 64'(a[31:0]));
      end
    end
  end

  function automatic req_t rnd_req();
    req_t        r;
    int          kind, nb;
    logic [31:0] a;
    logic [5:0]  sz;
    kind = $urandom_range(0, 2);
    case ($urandom_range(0, 3))
      0: sz = 6'd8;
      1: sz = 6'd16;
      2: sz = 6'd32;
      default: sz = ($urandom_range(0, 7) == 0) ? 6'd24 : 6'd32;
    endcase
    if ($urandom_range(0, 15) == 0) a = BASE + 32'd256 + 32'($urandom_range(0, 1000));
    else if ($urandom_range(0, 1) == 0) a = BASE + 32'($urandom_range(0, 31));
    else a = BASE + 32'($urandom_range(0, 255));
    nb = (sz == 6'd16) ? 2 : (sz == 6'd32) ? 4 : 1;
    if ($urandom_range(0, 7) != 0) a = a & ~32'(nb - 1);
    r = mk(kind == 1, kind == 2, a, $urandom, sz);
    if (kind == 0) r = mk(0, 0, 0, 0, 0);
    return r;
  endfunction

  req_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0);
    cyc(1, idle, idle, 0, 0, 0);
    cyc(1, idle, idle, 0, 0, 0);
    // 1: ch0 write, ch1 read back
    cyc(0, mk(0, 1, BASE, 32'hDEADBEEF, 32), idle, 0, 0, 0);
    cyc(0, idle, mk(1, 0, BASE, 0, 32), 0, 0, 0);
    // 2: byte writes, sub-word reads, host readback
    cyc(0, mk(0, 1, BASE + 4, 32'h11, 8), idle, 0, 0, 0);
    cyc(0, mk(0, 1, BASE + 5, 32'h22, 8), idle, 0, 0, 0);
    cyc(0, mk(0, 1, BASE + 6, 32'h33, 8), idle, 0, 0, 0);
    cyc(0, mk(0, 1, BASE + 7, 32'h44, 8), idle, 0, 0, 0);
    cyc(0, mk(1, 0, BASE + 6, 0, 16), idle, 0, 1, 0);
    cyc(0, mk(1, 0, BASE + 5, 0, 8), idle, 0, 1, 0);
    // 3: same-word dual write, ch1 wins on overlap
    cyc(0, mk(0, 1, BASE + 8, 32'hAAAAAAAA, 32), mk(0, 1, BASE + 8, 32'h0000BBBB, 16), 0, 2, 0);
    cyc(0, mk(1, 0, BASE + 8, 0, 32), idle, 0, 2, 0);
    // 4: out-of-range read and misaligned write
    cyc(0, mk(1, 0, BASE + 32'h100, 0, 32), mk(0, 1, BASE + 2, 32'h12345678, 32), 0, 0, 0);
    cyc(0, mk(1, 0, BASE, 0, 32), idle, 0, 0, 0);
    cyc(0, idle, idle, 0, 0, 0);
    // 5: host preload, read-before-write on host port
    cyc(1, idle, idle, 0, 0, 0);
    cyc(0, idle, idle, 1, 0, 32'h00000080);
    cyc(0, mk(1, 0, BASE, 0, 32), idle, 0, 0, 0);
    cyc(0, mk(0, 1, BASE, 32'h55667788, 32), idle, 0, 0, 0);
    cyc(0, idle, idle, 0, 0, 0);
    // host write and core write same word: core wins on overlap
    cyc(0, mk(0, 1, BASE + 12, 32'h99, 8), idle, 1, 3, 32'hCAFEF00D);
    cyc(0, idle, idle, 0, 3, 0);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)
        cyc(0, rnd_req(), rnd_req(), 1, 6'($urandom_range(0, 63)), $urandom);
      else
        cyc(0, rnd_req(), rnd_req(), 0, 6'($urandom_range(0, 63)), 0);
      if ($urandom_range(0, 499) == 0) cyc(1, idle, idle, 0, 0, 0);
    end
    // both oe and we on one channel: single ack, err
    cyc(1, idle, idle, 0, 0, 0);
    cyc(0, mk(1, 1, BASE + 16, 32'h01020304, 32), idle, 0, 0, 0);
    cyc(0, idle, idle, 0, 0, 0);
    // 6: reset in the cycle of a read request
    cyc(0, mk(0, 1, BASE + 20, 32'hFFFFFFFF, 32), idle, 0, 0, 0);
    cyc(1, mk(1, 0, BASE + 20, 0, 32), idle, 0, 0, 0);
    cyc(0, mk(1, 0, BASE + 20, 0, 32), mk(1, 0, BASE + 8, 0, 32), 0, 5, 0);
    cyc(0, idle, idle, 0, 0, 0);
    @(negedge clk); #1;
    chk("ackq0_drained", 64'(ackq0.size()), 64'd0);
    chk("ackq1_drained", 64'(ackq1.size()), 64'd0);
    chk("stq_drained", 64'(stq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/md5_mem_responder.md
Name: md5_mem_responder

Overview:
- Memory responder (slave) for the dual-channel minimal memory interface driven by the HLS-generated md5 core.
- Replaces ad-hoc stub read data with a real word-addressed register-array RAM.
- Serves both core channels with fixed 1-cycle latency.
- Provides a host port for message preload and digest readback, plus a sticky error flag for illegal accesses.

Parameters:
- BASE_ADDR, 32'h40000000, byte address mapped to word 0.
- DEPTH, 64, number of 32-bit words; power of two, 4..1024.
- AW, 6, word index width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- Mout_oe_ram  input  2  per-channel read request; bit i is channel i
- Mout_we_ram  input  2  per-channel write request
- Mout_addr_ram  input  64  byte addresses; ch0 [31:0], ch1 [63:32]
- Mout_Wdata_ram  input  64  write data, right-justified; ch0 [31:0], ch1 [63:32]
- Mout_data_ram_size  input  12  access size in bits; ch0 [5:0], ch1 [11:6]; legal values 8, 16, 32
- M_Rdata_ram  output  64  read data; ch0 [31:0], ch1 [63:32]
- M_DataRdy  output  2  per-channel completion pulse
- host_we  input  1  host word write
- host_addr  input  AW  host word index
- host_wdata  input  32  host write data
- host_rdata  output  32  host read data, 1-cycle latency
- err  output  1  sticky illegal-access flag

Behaviour:
- Reset (synchronous, active-high):
  - M_DataRdy=0, M_Rdata_ram=0, host_rdata=0, err=0.
  - All RAM words cleared to 0 (clearing completes by the first edge after reset deasserts).
  - Pending acks from the reset cycle are discarded.
- Request decode, per channel i, each cycle:
  - req = oe|we.
  - off = addr - BASE_ADDR (32-bit wrap), word = off[AW+1:2], lane = off[1:0].
- Legal access requires all of:
  - off < 4*DEPTH;
  - size in {8,16,32};
  - alignment: 16-bit needs lane[0]=0; 32-bit needs lane=0.
- Illegal access:
  - write dropped; read returns 0; err set on the next edge (sticky until reset).
  - M_DataRdy is still pulsed so the core never hangs.
- oe and we both high on one channel: treated as write, single ack, err set.
- Latency: request sampled at edge N; at edge N+1 M_DataRdy[i]=1 for exactly one cycle.
  - Back-to-back requests give consecutive pulses; there is no stall path.
- Reads:
  - Data lane = word >> (8*lane), masked to size bits, zero-extended, in the channel's low bits.
  - Read data is held until the next read completes on that channel; non-read cycles leave it unchanged.
- Writes:
  - Only the addressed bytes change (byte enables from size and lane).
  - Data taken from Wdata[size-1:0] of that channel.
- Same-word writes on both channels in one cycle:
  - byte enables merged; on overlapping bytes channel 1 wins.
- Host write to the same word in the same cycle: core channels win on overlapping bytes.
- Read of a word written in the same cycle by another channel or the host returns the OLD value (read-before-write).
- Host port:
  - host_rdata = RAM[host_addr] registered each cycle, also read-before-write.
  - host_we writes a full word.
  - Host accesses are never flagged illegal.
- Pipeline structure: no FSM beyond the per-channel ack register and the err register; all outputs are registered.

Test Plan:
1. Reset, then ch0 write 32-bit 0xDEADBEEF to 0x40000000, then ch1 read 32-bit at 0x40000000 → M_DataRdy=2'b01 one cycle after the write; one cycle after the read, M_DataRdy=2'b10 and M_Rdata_ram[63:32]=0xDEADBEEF.
2. Byte writes 0x11, 0x22, 0x33, 0x44 to 0x40000004..07, then ch0 16-bit read at 0x40000006 → 0x00004433; 8-bit read at 0x40000005 → 0x00000022; host_rdata for word 1 → 0x44332211.
3. Same cycle: ch0 32-bit write 0xAAAAAAAA and ch1 16-bit write 0xBBBB, both to 0x40000008 → word 2 = 0xAAAABBBB; M_DataRdy=2'b11 for one cycle.
4. ch0 read at 0x40000100 (out of range for DEPTH=64) and ch1 32-bit write at 0x40000002 (misaligned) → both acked; read data 0; no RAM change; err=1 until reset.
5. Host preloads word 0 = 0x00000080, then ch0 read at 0x40000000 → 0x00000080. Same-cycle host read and ch0 write to word 0 → host_rdata shows the old value, and the new value the following cycle.
6. Assert reset in the cycle of a ch0 read request → no M_DataRdy pulse; M_Rdata_ram=0, err=0; subsequent read of any word returns 0.
